multicycle_chunk_adder: RTL and testbench

//   Parametrised WIDTH-bit add/subtract unit. Each operation is processed CHUNK bits per clock,

---
 rtl/multicycle_chunk_adder_pkg.sv | 17 +
 rtl/chunk_adder.sv | 25 ++
 rtl/multicycle_chunk_adder.sv | 120 ++++++++++++
 tb/tb_multicycle_chunk_adder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared types for the multi-cycle chunked adder: FSM encoding and index-width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the slice index; never narrower than one bit so a single-slice build still has a counter.
  function automatic int idx_width(input int nchunk);
    int w;
    w = $clog2(nchunk);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic carry;

  // Carry rippled through a block variable so no vector feeds back on itself.
  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/multicycle_chunk_adder.sv
// WIDTH-bit add/subtract unit that processes CHUNK bits per clock behind valid/ready handshakes.
module multicycle_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("multicycle_chunk_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  state_t state, state_nxt;

  logic [NCHUNK-1:0][CHUNK-1:0] a_q, beff_q, sum_q;
  logic                         carry_q;
  logic [IDXW-1:0]              idx_q;
  logic                         carry_out_q, overflow_q;

  logic [CHUNK-1:0] slice_sum;
  logic             slice_co;
  logic             last_slice;

  assign last_slice = (idx_q == IDXW'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x  (a_q[idx_q]),
    .y  (beff_q[idx_q]),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)   state_nxt = ST_RUN;
      ST_RUN:  if (last_slice) state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      beff_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q         <= a;
            beff_q      <= sub ? ~b : b;
            carry_q     <= carry_in;
            idx_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_q[idx_q] <= slice_sum;
          carry_q      <= slice_co;
          idx_q        <= idx_q + IDXW'(1);
          // The final slice holds the MSB, so the flags come straight from this slice.
          if (last_slice) begin
            carry_out_q <= slice_co;
            overflow_q  <= (a_q[NCHUNK-1][CHUNK-1] == beff_q[NCHUNK-1][CHUNK-1]) &&
                           (slice_sum[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Directed and random checks of multicycle_chunk_adder at WIDTH=16, CHUNK=4.
module tb_multicycle_chunk_adder;

  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          carry_in = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          carry_out;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] esum;
    logic         eco;
    logic         eov;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one operation, scramble the operand inputs after accept, wait for the result and hand it off.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tsub, output logic [W-1:0] rs, output logic rco,
                        output logic rov, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = ta; b = tb_v; carry_in = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = 16'h5A5A; carry_in = ~tcin; sub = ~tsub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rco = carry_out; rov = overflow;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rs, held_sum;
    logic         rco, rov, held_co, held_ov;
    logic [W:0]   model;
    logic [W-1:0] beff;
    int           lat;

    vecs[0]  = '{16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[11] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

    #2;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_sum", 32'(sum), 32'h0);
    check("reset_flags", {30'h0, carry_out, overflow}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, rs, rco, rov, lat);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].esum));
      check($sformatf("vec%0d_flags", i), {30'h0, rco, rov}, {30'h0, vecs[i].eco, vecs[i].eov});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(N));
      check($sformatf("vec%0d_handoff", i), {30'h0, out_valid, in_ready}, 32'h1);
    end

    // Backpressure: result held in DONE while out_ready=0, extra in_valid ignored.
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0101; b = 16'h0202;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(N));
    held_sum = sum; held_co = carry_out; held_ov = overflow;
    check("bp_sum", 32'(held_sum), 32'h8000);
    check("bp_flags", {30'h0, held_co, held_ov}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), {13'h0, out_valid, in_ready, carry_out, overflow, sum},
            {13'h0, 1'b1, 1'b0, held_co, held_ov, held_sum});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'h0, out_valid, in_ready}, 32'h1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_idle", {30'h0, out_valid, in_ready}, 32'h1);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; carry_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("midrun_partial_busy", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_sum", 32'(sum), 32'h0);
    check("midrun_rst_ctl", {29'h0, out_valid, carry_out, overflow}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("midrun_no_valid", 32'(lat), 32'h0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, rs, rco, rov, lat);
    check("after_rst_sum", 32'(rs), 32'h2345);
    check("after_rst_latency", 32'(lat), 32'(N));

    // Random operations against a plain arithmetic model.
    for (int r = 0; r < 200; r++) begin
      logic [W-1:0] ra, rb;
      logic rc, rsb, eov;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rsb = 1'($urandom);
      beff  = rsb ? ~rb : rb;
      model = {1'b0, ra} + {1'b0, beff} + {{W{1'b0}}, rc};
      eov   = (ra[W-1] == beff[W-1]) && (model[W-1] != ra[W-1]);
      run_op(ra, rb, rc, rsb, rs, rco, rov, lat);
      check($sformatf("rand%0d", r), {13'h0, lat[2:0], rco, rov, rs},
            {13'h0, 3'(N), model[W], eov, model[W-1:0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
